uart_cmd_master: RTL and testbench
==================================

// Module: uart_cmd_master
// PURPOSE
//  Host-side initiator for the UART debug command protocol. Accepts one command from local logic
//  (opcode + 0..4 payload bytes), serialises it through uart_tx, then collects a fixed-length
//  byte response from uart_rx. Used for board-to-board debug and on-chip self-test of the debug unit.
// PARAMETERS
//  NB_DATA         8        UART byte width
//  NB_RSP_LEN      8        width of response-length field (max 2^NB_RSP_LEN-1 bytes)
//  TIMEOUT_CYCLES  1000000  idle i_clk cycles allowed between response bytes before abort
// PORTS
//  i_clk             in   1           system clock
//  i_reset           in   1           asynchronous reset, active-high
//  i_cmd_valid       in   1           command request
//  o_cmd_ready       out  1           high only in IDLE; command accepted when valid&&ready
//  i_cmd_opcode      in   NB_DATA     opcode byte, sent first
//  i_cmd_payload     in   32          payload, sent little-endian (bits [7:0] first)
//  i_cmd_nb_payload  in   3           payload byte count 0..4; values 5..7 clamp to 4
//  i_rsp_len         in   NB_RSP_LEN  expected response bytes
//  o_tx_data         out  NB_DATA     byte to uart_tx
//  o_tx_start        out  1           one-cycle start pulse to uart_tx
//  i_tx_done         in   1           uart_tx completion pulse
//  i_rx_data         in   NB_DATA     byte from uart_rx
//  i_rx_done         in   1           uart_rx byte-valid pulse
//  o_rsp_data        out  NB_DATA     response byte
//  o_rsp_valid       out  1           one-cycle pulse per response byte
//  o_done            out  1           one-cycle pulse: transaction complete
//  o_timeout         out  1           one-cycle pulse: response timed out, transaction aborted
//  o_rsp_err         out  1           one-cycle pulse with o_done on checksum mismatch (macro only)
//  o_busy            out  1           high in any state except IDLE
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except o_cmd_ready=1; counters and latched command cleared.
//  - Reset mid-transaction aborts immediately; no o_done/o_timeout issued; o_tx_start forced 0.
//  - Accept: opcode, payload, count, rsp_len latched on valid&&ready; inputs may change afterwards.
//  - FSM: IDLE -> SEND (o_tx_start=1 one cycle, o_tx_data=current byte, held stable until i_tx_done)
//    -> WAIT_TX (wait i_tx_done) -> SEND for next byte, else RECV, else DONE.
//  - Byte order: opcode, payload[7:0], [15:8], ... up to count. Count 0 sends opcode only.
//  - First o_tx_start is the cycle after acceptance; next o_tx_start the cycle after i_tx_done.
//  - RECV: each i_rx_done -> o_rsp_data=i_rx_data, o_rsp_valid=1 next cycle; byte counter ++.
//    After i_rsp_len bytes -> DONE. i_rsp_len=0 skips RECV.
//  - DONE: o_done pulses one cycle, return to IDLE; o_cmd_ready=1 the following cycle.
//  - Timeout counter cleared on entering RECV and on each i_rx_done; reaching TIMEOUT_CYCLES-1
//    -> o_timeout pulse, IDLE. Partial response bytes already emitted are not retracted.
//  - i_rx_done outside RECV is ignored (stray bytes dropped). i_tx_done outside WAIT_TX ignored.
//  - i_rx_done and timeout expiry in the same cycle: byte wins, counter cleared.
//  - i_cmd_valid while busy has no effect.
// CONFIGURATION
//  CMD_MASTER_CHECKSUM_EN defined: after last payload byte, one extra byte = XOR of opcode and
//   sent payload bytes. Response then carries one extra trailing byte (not emitted on o_rsp_*),
//   compared to XOR of received bytes; mismatch -> o_rsp_err pulse together with o_done.
//  Not defined: no checksum byte sent or expected; o_rsp_err tied 0.
// TESTING
//  1. opcode 0x57, payload 0xDDCCBBAA, nb 4, rsp 0 -> tx 57,AA,BB,CC,DD; o_done 1 cycle after 5th tx_done.
//  2. opcode 0x52, nb 0, rsp 4; rx 11,22,33,44 -> o_rsp_valid x4 with same bytes, then o_done.
//  3. rsp 4, only 2 bytes arrive, TIMEOUT_CYCLES=100 -> o_timeout ~100 cycles after 2nd byte, no o_done.
//  4. Assert i_reset during 3rd byte of case 1 -> o_tx_start stays 0, o_cmd_ready=1, no pulses.
//  5. Stray i_rx_done=0xFF while in WAIT_TX, nb 5 requested -> byte ignored; only 4 payload bytes sent.
//  6. CMD_MASTER_CHECKSUM_EN: opcode 0x01, payload 0x03, nb 1 -> tx 01,03,02; rsp AA + chk 00 -> o_rsp_err.

Source files
------------

// File: rtl/uart_cmd_master.sv
// rtl/uart_cmd_master.sv - UART debug command initiator; optional checksum via CMD_MASTER_CHECKSUM_EN
`timescale 1ns/1ps
module uart_cmd_master #(
  parameter int NB_DATA        = 8,
  parameter int NB_RSP_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [NB_DATA-1:0]    i_cmd_opcode,
  input  logic [31:0]           i_cmd_payload,
  input  logic [2:0]            i_cmd_nb_payload,
  input  logic [NB_RSP_LEN-1:0] i_rsp_len,
  output logic [NB_DATA-1:0]    o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  input  logic [NB_DATA-1:0]    i_rx_data,
  input  logic                  i_rx_done,
  output logic [NB_DATA-1:0]    o_rsp_data,
  output logic                  o_rsp_valid,
  output logic                  o_done,
  output logic                  o_timeout,
  output logic                  o_rsp_err,
  output logic                  o_busy
);
  localparam int NB_TO  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int NB_CNT = NB_RSP_LEN + 1;

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_TX, S_RECV, S_DONE} state_t;
  state_t r_state, w_next;

  logic [NB_DATA-1:0]    r_opcode;
  logic [31:0]           r_payload;
  logic [2:0]            r_nb;
  logic [NB_RSP_LEN-1:0] r_rsp_len;
  logic [2:0]            r_idx;
  logic [NB_CNT-1:0]     r_rx_cnt;
  logic [NB_TO-1:0]      r_to_cnt;
  logic [NB_DATA-1:0]    r_rsp_data;
  logic                  r_rsp_valid;
  logic                  r_timeout;

  logic [2:0]            w_nb_clamped;
  logic [2:0]            w_last_idx;
  logic [NB_CNT-1:0]     w_rsp_total;
  logic                  w_rx_is_data;
  logic                  w_accept;
  logic                  w_last_tx;
  logic                  w_rx_last;
  logic                  w_to_expire;
  logic [NB_DATA-1:0]    w_cur_byte;

  assign w_nb_clamped = (i_cmd_nb_payload > 3'd4) ? 3'd4 : i_cmd_nb_payload;
  assign w_accept     = i_cmd_valid && (r_state == S_IDLE);
  assign w_last_tx    = (r_idx == w_last_idx);
  assign w_rx_last    = ((r_rx_cnt + NB_CNT'(1)) == w_rsp_total);
  assign w_to_expire  = (r_to_cnt == NB_TO'(TIMEOUT_CYCLES - 1));

`ifdef CMD_MASTER_CHECKSUM_EN
  logic [NB_DATA-1:0] r_tx_chk;
  logic [NB_DATA-1:0] r_rx_chk;
  logic [NB_DATA-1:0] w_chk_in;
  logic               r_rsp_err;

  // XOR of opcode and the payload bytes that will actually be sent
  always_comb begin
    w_chk_in = i_cmd_opcode;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < w_nb_clamped) w_chk_in = w_chk_in ^ NB_DATA'(i_cmd_payload[8*i +: 8]);
    end
  end

  assign w_last_idx   = r_nb + 3'd1;
  assign w_rsp_total  = {1'b0, r_rsp_len} + NB_CNT'(1);
  assign w_rx_is_data = (r_rx_cnt < {1'b0, r_rsp_len});
  assign o_rsp_err    = (r_state == S_DONE) && r_rsp_err;

  // Checksum state: latch tx checksum, accumulate rx XOR, compare trailing byte
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tx_chk  <= '0;
      r_rx_chk  <= '0;
      r_rsp_err <= 1'b0;
    end else if (w_accept) begin
      r_tx_chk  <= w_chk_in;
      r_rx_chk  <= '0;
      r_rsp_err <= 1'b0;
    end else if ((r_state == S_RECV) && i_rx_done) begin
      if (w_rx_is_data) r_rx_chk  <= r_rx_chk ^ i_rx_data;
      else              r_rsp_err <= (i_rx_data != r_rx_chk);
    end
  end
`else
  assign w_last_idx   = r_nb;
  assign w_rsp_total  = {1'b0, r_rsp_len};
  assign w_rx_is_data = 1'b1;
  assign o_rsp_err    = 1'b0;
`endif

  // Select the byte for the current transmit slot: opcode, payload LSB first, then checksum
  always_comb begin
    w_cur_byte = r_opcode;
    case (r_idx)
      3'd0:    w_cur_byte = r_opcode;
      3'd1:    w_cur_byte = NB_DATA'(r_payload[7:0]);
      3'd2:    w_cur_byte = NB_DATA'(r_payload[15:8]);
      3'd3:    w_cur_byte = NB_DATA'(r_payload[23:16]);
      default: w_cur_byte = NB_DATA'(r_payload[31:24]);
    endcase
`ifdef CMD_MASTER_CHECKSUM_EN
    if (r_idx > r_nb) w_cur_byte = r_tx_chk;
`endif
  end

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_SEND;
      S_SEND:    w_next = S_WAIT_TX;
      S_WAIT_TX: begin
        if (i_tx_done) begin
          if (!w_last_tx)              w_next = S_SEND;
          else if (r_rsp_len == '0)    w_next = S_DONE;
          else                         w_next = S_RECV;
        end
      end
      S_RECV: begin
        if (i_rx_done) begin
          if (w_rx_last) w_next = S_DONE;
        end else if (w_to_expire) begin
          w_next = S_IDLE;
        end
      end
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Datapath: command latch, byte index, response/timeout counters, response pulses
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_opcode    <= '0;
      r_payload   <= '0;
      r_nb        <= '0;
      r_rsp_len   <= '0;
      r_idx       <= '0;
      r_rx_cnt    <= '0;
      r_to_cnt    <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_timeout   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_opcode  <= i_cmd_opcode;
            r_payload <= i_cmd_payload;
            r_nb      <= w_nb_clamped;
            r_rsp_len <= i_rsp_len;
            r_idx     <= '0;
          end
        end
        S_WAIT_TX: begin
          if (i_tx_done) begin
            if (!w_last_tx) r_idx <= r_idx + 3'd1;
            r_rx_cnt <= '0;
            r_to_cnt <= '0;
          end
        end
        S_RECV: begin
          if (i_rx_done) begin
            r_to_cnt <= '0;
            r_rx_cnt <= r_rx_cnt + NB_CNT'(1);
            if (w_rx_is_data) begin
              r_rsp_data  <= i_rx_data;
              r_rsp_valid <= 1'b1;
            end
          end else if (w_to_expire) begin
            r_timeout <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + NB_TO'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_tx_start  = (r_state == S_SEND);
  assign o_tx_data   = ((r_state == S_SEND) || (r_state == S_WAIT_TX)) ? w_cur_byte : '0;
  assign o_done      = (r_state == S_DONE);
  assign o_timeout   = r_timeout;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_valid = r_rsp_valid;

endmodule

// File: tb/tb_uart_cmd_master.sv
// tb/tb_uart_cmd_master.sv - directed and random checks of uart_cmd_master against a byte-level model
`timescale 1ns/1ps
module tb_uart_cmd_master;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [7:0]  i_cmd_opcode;
  logic [31:0] i_cmd_payload;
  logic [2:0]  i_cmd_nb_payload;
  logic [7:0]  i_rsp_len;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done;
  logic [7:0]  i_rx_data;
  logic        i_rx_done;
  logic [7:0]  o_rsp_data;
  logic        o_rsp_valid;
  logic        o_done;
  logic        o_timeout;
  logic        o_rsp_err;
  logic        o_busy;

  always #5 clk = ~clk;

  uart_cmd_master #(.NB_DATA(8), .NB_RSP_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_opcode(i_cmd_opcode), .i_cmd_payload(i_cmd_payload),
    .i_cmd_nb_payload(i_cmd_nb_payload), .i_rsp_len(i_rsp_len),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .o_rsp_data(o_rsp_data), .o_rsp_valid(o_rsp_valid),
    .o_done(o_done), .o_timeout(o_timeout), .o_rsp_err(o_rsp_err), .o_busy(o_busy)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rsp_q[$];
  logic [7:0] rx_src[$];
  logic [7:0] tx_held;
  int done_n, to_n, err_n, txd_n;
  int done_cyc, to_cyc, txdone_cyc, first_start, acc_cyc;
  bit tx_busy = 0;

  function automatic int now_cyc();
    return int'($time / 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: records transmitted bytes, response bytes and status pulses
  initial forever begin
    @(negedge clk);
    if (o_tx_start) begin
      if (tx_q.size() == 0) first_start = now_cyc();
      tx_q.push_back(o_tx_data);
    end
    if (o_rsp_valid) rsp_q.push_back(o_rsp_data);
    if (o_done) begin
      done_n++;
      done_cyc = now_cyc();
      if (o_rsp_err) err_n++;
    end
    if (o_timeout) begin
      to_n++;
      to_cyc = now_cyc();
    end
  end

  // uart_tx stand-in: random serialisation time, checks the byte is held, then pulses done
  initial begin
    i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      while (o_tx_start && !rst) begin
        tx_held = o_tx_data;
        tx_busy = 1;
        repeat ($urandom_range(1, 4)) begin
          @(negedge clk);
          if (o_busy && !rst) chk("tx_data_hold", 32'(o_tx_data), 32'(tx_held));
        end
        i_tx_done  = 1'b1;
        txd_n++;
        txdone_cyc = now_cyc();
        @(negedge clk);
        i_tx_done = 1'b0;
        tx_busy   = 0;
      end
    end
  end

  task automatic issue(input logic [7:0] op, input logic [31:0] pl, input logic [2:0] nb,
                       input logic [7:0] rl);
    int t;
    t = 0;
    while (!o_cmd_ready && t < 200) begin @(negedge clk); t++; end
    chk("ready_before_cmd", 32'(o_cmd_ready), 32'd1);
    tx_q.delete(); rsp_q.delete();
    done_n = 0; to_n = 0; err_n = 0; txd_n = 0; first_start = -1;
    i_cmd_opcode = op; i_cmd_payload = pl; i_cmd_nb_payload = nb; i_rsp_len = rl;
    i_cmd_valid = 1'b1;
    acc_cyc = now_cyc();
    @(negedge clk);
    i_cmd_valid      = 1'b0;
    i_cmd_opcode     = 8'($urandom);
    i_cmd_payload    = $urandom;
    i_cmd_nb_payload = 3'($urandom);
    i_rsp_len        = 8'($urandom);
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [31:0] pl, input logic [2:0] nb,
                         input logic [7:0] rl, input bit corrupt, input bit exp_to, input bit stray);
    logic [7:0] exp_tx[$];
    logic [7:0] rx_send[$];
    logic [7:0] x;
    int k, t, last_rx, exp_err;
    bit stray_done;
    exp_err = 0;
    last_rx = 0;
    // reference: opcode, then min(nb,4) payload bytes LSB first, then optional XOR byte
    k = (nb > 3'd4) ? 4 : int'(nb);
    x = op;
    exp_tx.push_back(op);
    for (int i = 0; i < k; i++) begin
      exp_tx.push_back(pl[8*i +: 8]);
      x = x ^ pl[8*i +: 8];
    end
`ifdef CMD_MASTER_CHECKSUM_EN
    exp_tx.push_back(x);
`endif
    foreach (rx_src[i]) rx_send.push_back(rx_src[i]);
`ifdef CMD_MASTER_CHECKSUM_EN
    if (rl != 8'd0 && rx_src.size() == int'(rl)) begin
      x = 8'h00;
      foreach (rx_src[i]) x = x ^ rx_src[i];
      rx_send.push_back(corrupt ? (x ^ 8'hAA) : x);
      exp_err = corrupt ? 1 : 0;
    end
`endif

    issue(op, pl, nb, rl);

    t = 0;
    stray_done = 0;
    while ((txd_n < exp_tx.size() || tx_busy) && t < 3000) begin
      if (stray && !stray_done && tx_q.size() >= 2) begin
        i_rx_data  = 8'hFF;
        i_rx_done  = 1'b1;
        stray_done = 1;
      end
      @(negedge clk);
      i_rx_done = 1'b0;
      t++;
    end
    @(negedge clk);

    if (rl != 8'd0) begin
      foreach (rx_send[i]) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        i_rx_data = rx_send[i];
        i_rx_done = 1'b1;
        last_rx   = now_cyc();
        @(negedge clk);
        i_rx_done = 1'b0;
        i_rx_data = 8'($urandom);
      end
    end

    t = 0;
    while (done_n == 0 && to_n == 0 && t < TO + 50) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);

    chk("tx_count", 32'(tx_q.size()), 32'(exp_tx.size()));
    foreach (exp_tx[i]) if (i < tx_q.size()) chk("tx_byte", 32'(tx_q[i]), 32'(exp_tx[i]));
    chk("rsp_count", 32'(rsp_q.size()), 32'(rx_src.size()));
    foreach (rx_src[i]) if (i < rsp_q.size()) chk("rsp_byte", 32'(rsp_q[i]), 32'(rx_src[i]));
    chk("first_start_latency", 32'(first_start), 32'(acc_cyc + 1));
    if (exp_to) begin
      chk("timeout_pulses", 32'(to_n), 32'd1);
      chk("done_pulses_on_timeout", 32'(done_n), 32'd0);
      chk("timeout_latency_window",
          32'((to_cyc - last_rx >= TO - 2) && (to_cyc - last_rx <= TO + 2)), 32'd1);
    end else begin
      chk("done_pulses", 32'(done_n), 32'd1);
      chk("timeout_pulses", 32'(to_n), 32'd0);
      chk("done_latency", 32'(done_cyc), 32'((rl == 8'd0) ? txdone_cyc + 1 : last_rx + 1));
      chk("rsp_err_pulses", 32'(err_n), 32'(exp_err));
    end
    chk("ready_after", 32'(o_cmd_ready), 32'd1);
    chk("busy_after", 32'(o_busy), 32'd0);
  endtask

  initial begin
    int t;
    logic [7:0] rl;
    rst = 1'b1;
    i_cmd_valid = 1'b0; i_cmd_opcode = '0; i_cmd_payload = '0;
    i_cmd_nb_payload = '0; i_rsp_len = '0; i_rx_data = '0; i_rx_done = 1'b0;
    done_n = 0; to_n = 0; err_n = 0; txd_n = 0;
    repeat (2) @(negedge clk);

    chk("reset_cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_tx_start", 32'(o_tx_start), 32'd0);
    chk("reset_tx_data", 32'(o_tx_data), 32'd0);
    chk("reset_done", 32'(o_done), 32'd0);
    chk("reset_timeout", 32'(o_timeout), 32'd0);
    chk("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(o_rsp_data), 32'd0);
    chk("reset_rsp_err", 32'(o_rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // write with full payload, no response
    rx_src.delete();
    run_cmd(8'h57, 32'hDDCCBBAA, 3'd4, 8'd0, 1'b0, 1'b0, 1'b0);

    // read, four response bytes
    rx_src = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_cmd(8'h52, 32'h0, 3'd0, 8'd4, 1'b0, 1'b0, 1'b0);

    // short response ends in timeout
    rx_src = '{8'h61, 8'h62};
    run_cmd(8'h33, 32'h0000BEEF, 3'd2, 8'd4, 1'b0, 1'b1, 1'b0);

    // reset during the third transmitted byte
    issue(8'h57, 32'hDDCCBBAA, 3'd4, 8'd0);
    t = 0;
    while (tx_q.size() < 3 && t < 500) begin @(negedge clk); t++; end
    chk("reset_reached_3rd_byte", 32'(tx_q.size() >= 3), 32'd1);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx_start", 32'(o_tx_start), 32'd0);
    chk("midrst_ready", 32'(o_cmd_ready), 32'd1);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_done", 32'(done_n), 32'd0);
    chk("midrst_no_timeout", 32'(to_n), 32'd0);
    chk("midrst_no_rsp", 32'(rsp_q.size()), 32'd0);
    chk("midrst_no_more_tx", 32'(tx_q.size()), 32'd3);
    chk("midrst_ready_after", 32'(o_cmd_ready), 32'd1);
    t = 0;
    while (tx_busy && t < 20) begin @(negedge clk); t++; end

    // stray rx byte during transmit, count 5 clamps to 4
    rx_src.delete();
    run_cmd(8'h10, 32'h44332211, 3'd5, 8'd0, 1'b0, 1'b0, 1'b1);

`ifdef CMD_MASTER_CHECKSUM_EN
    // bad trailing checksum flags o_rsp_err
    rx_src = '{8'hAA};
    run_cmd(8'h01, 32'h00000003, 3'd1, 8'd1, 1'b1, 1'b0, 1'b0);
`endif

    // random commands
    for (int n = 0; n < 8; n++) begin
      rl = 8'($urandom_range(0, 5));
      rx_src.delete();
      for (int i = 0; i < int'(rl); i++) rx_src.push_back(8'($urandom));
      run_cmd(8'($urandom), $urandom, 3'($urandom_range(0, 7)), rl,
              1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "time limit");
  end

endmodule
